// File: rtl/operand_skew_feeder_pkg.sv
// Shared constants and types for the systolic-array operand feeders.
// The widths are common to the input memories, both feeders and the PE array.
// The state encoding is used by the feeder control FSM.
package operand_skew_feeder_pkg;

   localparam int LANES  = 4;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int LEN_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef logic [DATA_W-1:0] lane_t;

endpackage

// File: rtl/operand_skew_feeder_skew_delay_line.sv
// Per-lane skew: DEPTH plain shift stages followed by one output register.
// The output register shows zero whenever the valid bit reaching it is clear.
// Latency is DEPTH+1 cycles. There is no backpressure: the line always shifts.
module skew_delay_line
   import operand_skew_feeder_pkg::*;
#(
   parameter int DEPTH = 0
)
(
   input  logic  clk,
   input  logic  rst,
   input  lane_t in_data,
   input  logic  in_vld,
   output lane_t out_data
);

   lane_t tail_data;
   logic  tail_vld;

   generate
      if (DEPTH == 0) begin : g_direct
         assign tail_data = in_data;
         assign tail_vld  = in_vld;
      end else begin : g_stages
         lane_t stg_data [DEPTH];
         logic  stg_vld  [DEPTH];

         // Shift data and valid together through DEPTH stages
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int j = 0; j < DEPTH; j++) begin
                  stg_data[j] <= '0;
                  stg_vld[j]  <= 1'b0;
               end
            end else begin
               stg_data[0] <= in_data;
               stg_vld[0]  <= in_vld;
               for (int j = 1; j < DEPTH; j++) begin
                  stg_data[j] <= stg_data[j-1];
                  stg_vld[j]  <= stg_vld[j-1];
               end
            end
         end

         assign tail_data = stg_data[DEPTH-1];
         assign tail_vld  = stg_vld[DEPTH-1];
      end
   endgenerate

   // Output register; invalid slots are fed to the array as zero operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
      end else begin
         out_data <= tail_vld ? tail_data : '0;
      end
   end

endmodule

// File: rtl/operand_skew_feeder.sv
// Streams K column words from the operand memory into the systolic array edge.
// Lane i is skewed by i cycles. Zeros are fed, then FLUSH extra zero cycles.
// Start to done takes len+5+FLUSH cycles. Starts are ignored while busy (no queuing).
module operand_skew_feeder
   import operand_skew_feeder_pkg::*;
#(
   parameter int FLUSH = 2*LANES-2
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              clear_acc,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data0,
   input  logic [DATA_W-1:0] rd_data1,
   input  logic [DATA_W-1:0] rd_data2,
   input  logic [DATA_W-1:0] rd_data3,
   output logic [DATA_W-1:0] a0,
   output logic [DATA_W-1:0] a1,
   output logic [DATA_W-1:0] a2,
   output logic [DATA_W-1:0] a3
);

   // DRAIN covers the LANES cycles until lane 3 shows its last element, then FLUSH.
   localparam int DRAIN_CYC = LANES + FLUSH;
   localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

   state_t             state;
   logic [LEN_W-1:0]   issue_cnt;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               rd_vld;
   lane_t              lane_in  [LANES];
   lane_t              lane_out [LANES];

   // Job control: issues reads, times the drain, and produces the pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         clear_acc <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         issue_cnt <= '0;
         drain_cnt <= '0;
      end else begin
         done      <= 1'b0;
         clear_acc <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state     <= ISSUE;
                     busy      <= 1'b1;
                     clear_acc <= 1'b1;
                     rd_en     <= 1'b1;
                     rd_addr   <= base_addr;
                     issue_cnt <= len - LEN_W'(1);
                  end else begin
                     // Empty job: nothing to stream, acknowledge at once
                     done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (issue_cnt == '0) begin
                  rd_en     <= 1'b0;
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_W'(DRAIN_CYC);
               end else begin
                  issue_cnt <= issue_cnt - LEN_W'(1);
                  rd_addr   <= rd_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               // done shows while drain_cnt is 0; busy drops after that cycle
               if (drain_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
                  if (drain_cnt == DRAIN_W'(1)) begin
                     done <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Valid bit aligned with the memory's one-cycle read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld <= 1'b0;
      end else begin
         rd_vld <= rd_en;
      end
   end

   assign lane_in[0] = rd_data0;
   assign lane_in[1] = rd_data1;
   assign lane_in[2] = rd_data2;
   assign lane_in[3] = rd_data3;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         skew_delay_line #(.DEPTH(i)) u_skew (
            .clk      (clk),
            .rst      (rst),
            .in_data  (lane_in[i]),
            .in_vld   (rd_vld),
            .out_data (lane_out[i])
         );
      end
   endgenerate

   assign a0 = lane_out[0];
   assign a1 = lane_out[1];
   assign a2 = lane_out[2];
   assign a3 = lane_out[3];

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder. A behavioural memory returns {lane, addr, 4'h0}.
// Each test task checks captured outputs against the expected skew timing.
// A job runs in the order start, c0, ISSUE, DRAIN, done.
module tb_operand_skew_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  len = 4'd0;
   logic [7:0]  base_addr = 8'd0;
   logic        busy, done, clear_acc, rd_en;
   logic [7:0]  rd_addr;
   logic [15:0] rd_data0 = '0, rd_data1 = '0, rd_data2 = '0, rd_data3 = '0;
   logic [15:0] a0, a1, a2, a3;

   int total = 0;
   int bad   = 0;

   // Capture buffers; index t is the offset from c0
   logic [15:0] cap_a    [32][4];
   logic        cap_en   [32];
   logic        cap_done [32];
   logic        cap_busy [32];
   logic        cap_clr  [32];
   logic [7:0]  cap_addr [32];

   always #5 clk = ~clk;

   operand_skew_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .clear_acc (clear_acc),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data0  (rd_data0),
      .rd_data1  (rd_data1),
      .rd_data2  (rd_data2),
      .rd_data3  (rd_data3),
      .a0        (a0),
      .a1        (a1),
      .a2        (a2),
      .a3        (a3)
   );

   // Operand memory with one-cycle read latency
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data0 <= {4'h0, rd_addr, 4'h0};
         rd_data1 <= {4'h1, rd_addr, 4'h0};
         rd_data2 <= {4'h2, rd_addr, 4'h0};
         rd_data3 <= {4'h3, rd_addr, 4'h0};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lane i carries element k = t-2-i at offset t from c0, and zero otherwise
   function automatic logic [15:0] exp_lane(input int lane, input int t, input int ln, input logic [7:0] b);
      int k;
      logic [7:0] ad;
      k = t - 2 - lane;
      if (k < 0 || k >= ln) return 16'h0000;
      ad = b + 8'(k);
      return {4'(lane), ad, 4'h0};
   endfunction

   // Starts a job and records n cycles from c0. When t == collide_t a stray start is pulsed.
   task automatic run_job(input int ln, input logic [7:0] b, input int collide_t, input int n);
      start = 1'b1;
      len = 4'(ln);
      base_addr = b;
      tick();
      start = 1'b0;
      for (int t = 0; t < n; t++) begin
         if (t == collide_t) begin
            start = 1'b1;
            len = 4'd1;
            base_addr = 8'hAA;
         end else begin
            start = 1'b0;
         end
         cap_a[t][0] = a0;
         cap_a[t][1] = a1;
         cap_a[t][2] = a2;
         cap_a[t][3] = a3;
         cap_en[t]   = rd_en;
         cap_done[t] = done;
         cap_busy[t] = busy;
         cap_clr[t]  = clear_acc;
         cap_addr[t] = rd_addr;
         tick();
      end
      start = 1'b0;
   endtask

   // Full cycle-by-cycle check of one job against the timing model
   task automatic test_stream(input int ln, input logic [7:0] b, input int collide_t);
      int n;
      logic [7:0] ea;
      n = ln + 14;
      run_job(ln, b, collide_t, n);
      for (int t = 0; t < n; t++) begin
         total++;
         if (cap_en[t] !== (t < ln)) begin
            bad++;
            $display("FAIL stream_rd_en len=%0d t=%0d got=%b want=%b", ln, t, cap_en[t], (t < ln));
         end
         if (t < ln) begin
            ea = b + 8'(t);
            total++;
            if (cap_addr[t] !== ea) begin
               bad++;
               $display("FAIL stream_rd_addr len=%0d t=%0d got=%h want=%h", ln, t, cap_addr[t], ea);
            end
         end
         for (int i = 0; i < 4; i++) begin
            total++;
            if (cap_a[t][i] !== exp_lane(i, t, ln, b)) begin
               bad++;
               $display("FAIL stream_a%0d len=%0d t=%0d got=%h want=%h", i, ln, t, cap_a[t][i], exp_lane(i, t, ln, b));
            end
         end
         total++;
         if (cap_done[t] !== (t == ln + 10)) begin
            bad++;
            $display("FAIL stream_done len=%0d t=%0d got=%b want=%b", ln, t, cap_done[t], (t == ln + 10));
         end
         total++;
         if (cap_busy[t] !== (t <= ln + 10)) begin
            bad++;
            $display("FAIL stream_busy len=%0d t=%0d got=%b want=%b", ln, t, cap_busy[t], (t <= ln + 10));
         end
         total++;
         if (cap_clr[t] !== (t == 0)) begin
            bad++;
            $display("FAIL stream_clear_acc len=%0d t=%0d got=%b want=%b", ln, t, cap_clr[t], (t == 0));
         end
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++;
      if ({busy, done, clear_acc, rd_en} !== 4'b0000 || rd_addr !== 8'h00 ||
          {a0, a1, a2, a3} !== 64'h0) begin
         bad++;
         $display("FAIL reset_state got=%b%b%b%b addr=%h a=%h%h%h%h want=all zero",
                  busy, done, clear_acc, rd_en, rd_addr, a0, a1, a2, a3);
      end
      rst = 1'b0;
      tick();
      // Abort a len=8 job in cycle c0+3
      start = 1'b1;
      len = 4'd8;
      base_addr = 8'h40;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      total++;
      if (a0 !== 16'h0410) begin
         bad++;
         $display("FAIL reset_prejob_a0 got=%h want=0410", a0);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({a0, a1, a2, a3} !== 64'h0 || {rd_en, busy, clear_acc, done} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_async a=%h%h%h%h en_busy_clr_done=%b%b%b%b want=all zero",
                  a0, a1, a2, a3, rd_en, busy, clear_acc, done);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done c=%0d done=%b busy=%b rd_en=%b want=0 0 0", c, done, busy, rd_en);
         end
         tick();
      end
      test_stream(2, 8'h60, -1);
   endtask

   task automatic test_hand_points();
      int en_cnt;
      int busy_cnt;
      logic [7:0]  addr_tab [4];
      logic [7:0]  wrap_tab [3];
      logic [15:0] a1_tab   [3];
      addr_tab = '{8'h10, 8'h11, 8'h12, 8'h13};
      wrap_tab = '{8'hFE, 8'hFF, 8'h00};
      a1_tab   = '{16'h1FE0, 16'h1FF0, 16'h1000};

      run_job(4, 8'h10, -1, 16);
      for (int t = 0; t < 4; t++) begin
         total++;
         if (cap_addr[t] !== addr_tab[t] || cap_en[t] !== 1'b1) begin
            bad++;
            $display("FAIL basic_addr t=%0d got=%h en=%b want=%h en=1", t, cap_addr[t], cap_en[t], addr_tab[t]);
         end
      end
      total++;
      if (cap_a[2][0] !== 16'h0100) begin bad++; $display("FAIL basic_a0_c2 got=%h want=0100", cap_a[2][0]); end
      total++;
      if (cap_a[4][2] !== 16'h2100) begin bad++; $display("FAIL basic_a2_c4 got=%h want=2100", cap_a[4][2]); end
      total++;
      if (cap_a[8][3] !== 16'h3130) begin bad++; $display("FAIL basic_a3_c8 got=%h want=3130", cap_a[8][3]); end
      total++;
      if (cap_a[9][3] !== 16'h0000) begin bad++; $display("FAIL basic_a3_c9 got=%h want=0000", cap_a[9][3]); end
      total++;
      if (cap_done[14] !== 1'b1 || cap_done[13] !== 1'b0) begin
         bad++;
         $display("FAIL basic_done c13=%b c14=%b want=0 1", cap_done[13], cap_done[14]);
      end
      total++;
      if (cap_clr[0] !== 1'b1 || cap_clr[1] !== 1'b0) begin
         bad++;
         $display("FAIL basic_clear_acc c0=%b c1=%b want=1 0", cap_clr[0], cap_clr[1]);
      end

      run_job(3, 8'hFE, -1, 14);
      for (int t = 0; t < 3; t++) begin
         total++;
         if (cap_addr[t] !== wrap_tab[t]) begin
            bad++;
            $display("FAIL wrap_addr t=%0d got=%h want=%h", t, cap_addr[t], wrap_tab[t]);
         end
         total++;
         if (cap_a[t+3][1] !== a1_tab[t]) begin
            bad++;
            $display("FAIL wrap_a1 t=%0d got=%h want=%h", t + 3, cap_a[t+3][1], a1_tab[t]);
         end
      end

      run_job(15, 8'h00, -1, 28);
      en_cnt = 0;
      busy_cnt = 0;
      for (int t = 0; t < 28; t++) begin
         if (cap_en[t]) en_cnt++;
         if (cap_busy[t]) busy_cnt++;
      end
      total++;
      if (en_cnt != 15) begin bad++; $display("FAIL max_rd_en_cycles got=%0d want=15", en_cnt); end
      total++;
      if (cap_a[19][3] !== 16'h30E0 || cap_a[20][3] !== 16'h0000) begin
         bad++;
         $display("FAIL max_a3_last c19=%h c20=%h want=30e0 0000", cap_a[19][3], cap_a[20][3]);
      end
      total++;
      if (cap_done[25] !== 1'b1 || cap_done[24] !== 1'b0) begin
         bad++;
         $display("FAIL max_done c24=%b c25=%b want=0 1", cap_done[24], cap_done[25]);
      end
      total++;
      if (busy_cnt != 26) begin bad++; $display("FAIL max_busy_cycles got=%0d want=26", busy_cnt); end
   endtask

   task automatic test_empty();
      start = 1'b1;
      len = 4'd0;
      base_addr = 8'h55;
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL empty_done_early got=%b want=0", done); end
      tick();
      start = 1'b0;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
         bad++;
         $display("FAIL empty_done done=%b busy=%b rd_en=%b want=1 0 0", done, busy, rd_en);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            bad++;
            $display("FAIL empty_after c=%0d done=%b busy=%b rd_en=%b want=0 0 0", c, done, busy, rd_en);
         end
      end
   endtask

   task automatic test_collisions();
      // start while busy: outputs must match a lone len=5 job
      test_stream(5, 8'h20, 3);
      // start in the done cycle (t=12 for len=2): no new job may begin
      test_stream(2, 8'h30, 12);
   endtask

   task automatic test_back_to_back();
      run_job(2, 8'h30, -1, 13);
      total++;
      if (cap_done[12] !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b want=1", cap_done[12]); end
      // Now one cycle after done: this start must be accepted
      run_job(3, 8'h50, -1, 17);
      total++;
      if (cap_clr[0] !== 1'b1 || cap_en[0] !== 1'b1 || cap_addr[0] !== 8'h50) begin
         bad++;
         $display("FAIL b2b_accept clr=%b en=%b addr=%h want=1 1 50", cap_clr[0], cap_en[0], cap_addr[0]);
      end
      total++;
      if (cap_done[13] !== 1'b1) begin bad++; $display("FAIL b2b_second_done got=%b want=1", cap_done[13]); end
   endtask

   initial begin
      test_reset();
      test_stream(4, 8'h10, -1);
      test_stream(3, 8'hFE, -1);
      test_hand_points();
      test_empty();
      test_collisions();
      test_back_to_back();
      test_stream(15, 8'h00, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_skew_feeder.md
Name: operand_skew_feeder

Overview:
- Upstream stage of the 4x4 systolic array.
- On a start pulse, reads K consecutive column words from one input memory (4 lanes x 16 bit, 1-cycle read latency) and applies the triangular skew: lane i is delayed by i cycles.
- Drives the array edge inputs, with zeros when no data is present, then flushes so the last partial products reach PE(3,3), and pulses done.
- Two instances per system: one for the A side, one for the B side. The sequencer starts both in the same cycle.

Parameters:
- LANES, 4, number of array rows/columns fed (skew depth LANES-1)
- DATA_W, 16, operand width per lane
- ADDR_W, 8, column address width per lane (256 columns)
- LEN_W, 4, width of the K (inner dimension) field from the instruction word
- FLUSH, 6, zero-feed cycles after the last skewed element (2*LANES-2)

Ports:
- clk in 1: clock, all state on posedge
- rst in 1: asynchronous, active-high reset
- start in 1: one-cycle request pulse; sampled only in IDLE
- len in LEN_W: K, number of columns to stream; 0 = empty job
- base_addr in ADDR_W: first column address
- busy out 1: job in progress
- done out 1: one-cycle completion pulse
- clear_acc out 1: one-cycle pulse telling the array to zero its accumulators
- rd_en out 1: memory read enable
- rd_addr out ADDR_W: memory column address
- rd_data0..rd_data3 in DATA_W each: memory lane outputs, valid the cycle after rd_en
- a0..a3 out DATA_W each: skewed operands to the array edge

Behaviour:
- Reset (asynchronous): state=IDLE. busy, done, clear_acc and rd_en are 0. rd_addr=0, a0..a3=0. All skew registers and valid bits cleared.
- Reset asserted mid-job: the job is aborted immediately, done is never pulsed, and the next start after rst deasserts begins cleanly.
- IDLE:
  - start=1 with len!=0: latch len and base_addr, pulse clear_acc for one cycle (the cycle after start), go to ISSUE.
  - start=1 with len==0: no reads, busy stays 0, done pulses in the cycle after start.
- ISSUE (first cycle called c0 = start cycle + 1):
  - rd_en=1 for exactly len cycles.
  - rd_addr = base+k for k=0..len-1, modulo 2^ADDR_W (0xFF wraps to 0x00).
  - After the last issue, go to DRAIN.
- Data path:
  - A valid bit follows each read.
  - Lane i output register presents element k in cycle c0+2+k+i; in every other cycle it presents 0.
  - Lane 0 uses only the output register; lane i adds i extra stages.
  - Zeros are produced by gating on the valid bit, not by resetting stages.
- DRAIN:
  - Counts down until lane 3's last element has been presented (cycle c0+len+4), then feeds FLUSH more zero cycles.
  - done is high in cycle c0+len+4+FLUSH, then state returns to IDLE.
- busy: high from c0 through the done cycle inclusive; low in IDLE.
- start while busy: ignored. No queuing, and latched len/base are not disturbed.
- start in the same cycle done is high: ignored; state returns to IDLE first.
- No arithmetic on data: operands pass through bit-exact. Address increment wraps silently.
- Total job latency, start to done: len+5+FLUSH cycles (15 for len=4, FLUSH=6).

Decomposition:
- Shared package holds:
  - LANES, DATA_W, ADDR_W, LEN_W constants, shared with the input memory and the array.
  - State encoding enum {IDLE, ISSUE, DRAIN}.
  - Lane data type.
- One sub-module, skew_delay_line (parameter DEPTH, data+valid in, data out gated to 0 when invalid). Instantiated per lane with DEPTH=i via generate.

Test Plan:
- Reset check: pulse rst mid-stream (rst high in cycle c0+3 of a len=8 job).
  - Required: a0..a3, rd_en, busy, clear_acc = 0 within the same cycle.
  - Required: no done pulse.
  - Required: a following len=2 job completes normally.
- Basic skew: memory model returns {lane[3:0], addr[7:0], 4'h0}; start with len=4, base=0x10.
  - Required: rd_addr 0x10..0x13 in c0..c0+3.
  - Required: a0=0x0100 at c0+2, a2=0x2100 at c0+4, a3=0x3130 at c0+8.
  - Required: a3=0 at c0+9; done at c0+14; clear_acc at c0.
- Wrap: len=3, base=0xFE.
  - Required: rd_addr sequence 0xFE, 0xFF, 0x00.
  - Required: a1 shows 0x1FE0, 0x1FF0, 0x1000 at c0+3..c0+5.
- Empty job: start with len=0.
  - Required: rd_en never high, busy stays 0, done high exactly one cycle after start.
- Start collisions:
  - start pulsed while busy (len=5 job): ignored; outputs match a lone len=5 job.
  - start pulsed in the done cycle: ignored, no new job.
  - start one cycle after done: accepted.
- Max length: len=15, base=0x00.
  - Required: rd_en high 15 cycles, a3 last element at c0+19, done at c0+25.
  - Required: busy high for exactly 26 cycles.
